// File: rtl/stream_rr_arbiter_pkg.sv
// ============================================================================
// stream_arb_pkg : shared types and helpers for stream_rr_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package stream_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n requesters; a lone requester still gets one bit.
    function automatic int rr_id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_rr_arbiter_if.sv
// ============================================================================
// stream_rr_arbiter_if : N-requester sink bundle plus merged source stream
// Revision: 1.0
// ============================================================================
`default_nettype none

interface stream_rr_arbiter_if #(
    parameter type QTYPE = logic [63:0],
    parameter int  N_REQ = 4
);
    import stream_arb_pkg::*;

    localparam int ID_BITS = rr_id_bits(N_REQ);

    logic [N_REQ-1:0]   val_snk;
    logic [N_REQ-1:0]   rdy_snk;
    QTYPE               data_snk [N_REQ];
    logic [N_REQ-1:0]   last_snk;

    logic               val_src;
    logic               rdy_src;
    QTYPE               data_src;
    logic               last_src;
    logic [ID_BITS-1:0] id_src;

    // slave: the arbiter itself; master: requesters plus downstream consumer
    modport slave (
        input  val_snk, data_snk, last_snk, rdy_src,
        output rdy_snk, val_src, data_src, last_src, id_src
    );

    modport master (
        output val_snk, data_snk, last_snk, rdy_src,
        input  rdy_snk, val_src, data_src, last_src, id_src
    );

endinterface

`default_nettype wire

// File: rtl/stream_rr_arbiter_rr_select.sv
// ============================================================================
// rr_select : combinational round-robin pick, searching from ptr_i+1 upward
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_select
    import stream_arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = rr_id_bits(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_oh_o,
    output logic [IDW-1:0] gnt_idx_o,
    output logic           any_o
);

    // One spare bit so ptr+k (at most 2N-1) never overflows before the wrap.
    logic [IDW:0] pos;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        pos       = '0;
        for (int k = 1; k <= N; k++) begin
            pos = {1'b0, ptr_i} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(N)) begin
                pos = pos - (IDW+1)'(N);
            end
            for (int j = 0; j < N; j++) begin
                if (!any_o && req_i[j] && (pos == (IDW+1)'(j))) begin
                    any_o       = 1'b1;
                    gnt_oh_o[j] = 1'b1;
                    gnt_idx_o   = IDW'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// stream_rr_arbiter : round-robin merge of N_REQ valid/ready streams into one
// registered output. Define STREAM_ARB_PKT_LOCK_EN to hold grant per packet.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter type QTYPE = logic [63:0],
    parameter int  N_REQ = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    stream_rr_arbiter_if.slave  bus
);

    localparam int ID_BITS = rr_id_bits(N_REQ);

    logic               val_q;
    QTYPE               data_q;
    logic               last_q;
    logic [ID_BITS-1:0] id_q;
    logic [ID_BITS-1:0] ptr_q;

    logic [N_REQ-1:0]   sel_oh;
    logic [ID_BITS-1:0] sel_idx;
    logic               sel_any;

    logic [N_REQ-1:0]   gnt_oh;
    logic [ID_BITS-1:0] gnt_idx;
    logic               load;
    logic               xfer;
    QTYPE               data_d;
    logic               last_d;

    rr_select #(
        .N (N_REQ)
    ) u_sel (
        .req_i     (bus.val_snk),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (sel_oh),
        .gnt_idx_o (sel_idx),
        .any_o     (sel_any)
    );

    assign load = !val_q || bus.rdy_src;

`ifdef STREAM_ARB_PKT_LOCK_EN
    arb_state_t         state_q;
    logic [ID_BITS-1:0] lid_q;
    logic [N_REQ-1:0]   lid_oh;

    always_comb begin
        lid_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            lid_oh[i] = (lid_q == ID_BITS'(i));
        end
    end

    // While locked the grant stays on lid even if it has nothing to send.
    assign gnt_oh  = (state_q == ARB_LOCKED) ? lid_oh : sel_oh;
    assign gnt_idx = (state_q == ARB_LOCKED) ? lid_q  : sel_idx;
    assign xfer    = load && ((state_q == ARB_LOCKED) ? |(lid_oh & bus.val_snk) : sel_any);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ARB_IDLE;
            lid_q   <= '0;
        end else if (xfer) begin
            case (state_q)
                ARB_IDLE: begin
                    if (!last_d) begin
                        state_q <= ARB_LOCKED;
                        lid_q   <= gnt_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (last_d) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
`else
    assign gnt_oh  = sel_oh;
    assign gnt_idx = sel_idx;
    assign xfer    = load && sel_any;
`endif

    always_comb begin
        data_d = '0;
        last_d = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_oh[i]) begin
                data_d = bus.data_snk[i];
                last_d = bus.last_snk[i];
            end
        end
    end

    // Reset pointer at N_REQ-1 so requester 0 is searched first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            val_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            id_q   <= '0;
            ptr_q  <= ID_BITS'(N_REQ - 1);
        end else if (load) begin
            val_q <= xfer;
            if (xfer) begin
                data_q <= data_d;
                last_q <= last_d;
                id_q   <= gnt_idx;
                ptr_q  <= gnt_idx;
            end
        end
    end

    assign bus.rdy_snk  = {N_REQ{load}} & gnt_oh;
    assign bus.val_src  = val_q;
    assign bus.data_src = data_q;
    assign bus.last_src = last_q;
    assign bus.id_src   = id_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// tb_stream_rr_arbiter : directed bench with a per-cycle reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

    localparam int NR = 4;

    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    stream_rr_arbiter_if #(.QTYPE(logic [63:0]), .N_REQ(NR)) bus  ();
    stream_rr_arbiter_if #(.QTYPE(logic [63:0]), .N_REQ(1))  bus1 ();

    stream_rr_arbiter #(.QTYPE(logic [63:0]), .N_REQ(NR)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    stream_rr_arbiter #(.QTYPE(logic [63:0]), .N_REQ(1)) dut1 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus1)
    );

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Requester beat lists; a requester is valid while it has beats left.
    logic [63:0] src_data [NR][16];
    logic        src_last [NR][16];
    int          src_cnt  [NR];
    int          src_pos  [NR];

    int          got_id   [$];
    logic [63:0] got_data [$];
    int          got_cyc  [$];
    int          exp_ids  [$];

    // Reference model state
    bit          m_val;
    logic [63:0] m_data;
    bit          m_last;
    int          m_id;
    int          m_ptr;
    bit          m_locked;
    int          m_lid;
    int          m_w;
    bit          m_have;
    bit          m_ld;
    logic [NR-1:0] m_rdy;
    int          cyc = 0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            m_val = 0; m_data = '0; m_last = 0; m_id = 0;
            m_ptr = NR - 1; m_locked = 0; m_lid = 0;
            chk("rst_val_src",  bus.val_src,  0);
            chk("rst_data_src", bus.data_src, 0);
            chk("rst_last_src", bus.last_src, 0);
            chk("rst_id_src",   bus.id_src,   0);
        end else begin
            chk("val_src", bus.val_src, m_val);
            if (m_val) begin
                chk("data_src", bus.data_src, m_data);
                chk("last_src", bus.last_src, m_last);
                chk("id_src",   bus.id_src,   m_id);
            end
            if (m_val && bus.rdy_src) begin
                got_id.push_back(m_id);
                got_data.push_back(m_data);
                got_cyc.push_back(cyc);
            end
            m_ld   = !m_val || bus.rdy_src;
            m_have = 0;
            m_w    = 0;
            if (m_locked) begin
                m_w = m_lid; m_have = 1;
            end else begin
                for (int k = 1; k <= NR; k++) begin
                    if (!m_have && bus.val_snk[(m_ptr + k) % NR]) begin
                        m_w = (m_ptr + k) % NR; m_have = 1;
                    end
                end
            end
            m_rdy = (m_ld && m_have) ? (NR'(1) << m_w) : '0;
            chk("rdy_snk", bus.rdy_snk, m_rdy);
            if (m_ld) begin
                if (m_have && bus.val_snk[m_w]) begin
                    m_val  = 1;
                    m_data = bus.data_snk[m_w];
                    m_last = bus.last_snk[m_w];
                    m_id   = m_w;
                    m_ptr  = m_w;
`ifdef STREAM_ARB_PKT_LOCK_EN
                    if (!m_locked && !m_last) begin
                        m_locked = 1; m_lid = m_w;
                    end else if (m_locked && m_last) begin
                        m_locked = 0;
                    end
`endif
                end else begin
                    m_val = 0;
                end
            end
        end
        cyc++;
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.val_snk[i]  = (src_pos[i] < src_cnt[i]);
            bus.data_snk[i] = src_data[i][src_pos[i] % 16];
            bus.last_snk[i] = src_last[i][src_pos[i] % 16];
        end
    endtask

    task automatic clear();
        for (int i = 0; i < NR; i++) begin
            src_cnt[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    task automatic add(int r, logic [63:0] d, bit l);
        src_data[r][src_cnt[r]] = d;
        src_last[r][src_cnt[r]] = l;
        src_cnt[r]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++) begin
            if (src_pos[i] < src_cnt[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance one cycle; requesters retire beats accepted at this edge.
    task automatic step();
        logic [NR-1:0] xf;
        @(negedge aclk);
        xf = aresetn ? (bus.val_snk & bus.rdy_snk) : '0;
        @(posedge aclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (xf[i]) src_pos[i]++;
        end
        drive();
    endtask

    task automatic drain();
        int n = 0;
        bus.rdy_src = 1'b1;
        while ((bus.val_src || pending()) && n < 60) begin
            step();
            n++;
        end
        chk("drain_bound", (n < 60), 1);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear();
        drive();
        step();
        step();
        aresetn = 1'b1;
    endtask

    task automatic start_capture();
        got_id.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    task automatic cmp_ids(string nm);
        chk({nm, "_count"}, (got_id.size() >= exp_ids.size()), 1);
        for (int i = 0; i < exp_ids.size() && i < got_id.size(); i++) begin
            chk($sformatf("%s_id%0d", nm, i), got_id[i], exp_ids[i]);
        end
    endtask

    task automatic cmp_no_bubble(string nm, int n);
        for (int i = 1; i < n && i < got_cyc.size(); i++) begin
            chk($sformatf("%s_cyc%0d", nm, i), got_cyc[i] - got_cyc[0], i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        bus.rdy_src = 1'b1;
        clear();
        drive();
        bus1.val_snk     = '0;
        bus1.data_snk[0] = '0;
        bus1.last_snk    = '0;
        bus1.rdy_src     = 1'b1;
        step();
        step();
        chk("reset_val_src", bus.val_src, 0);
        chk("reset_id_src",  bus.id_src,  0);
        aresetn = 1'b1;

        // Single requester 2: A,B,C back to back, one cycle latency
        start_capture();
        add(2, 64'hA0, 0); add(2, 64'hB0, 0); add(2, 64'hC0, 1);
        drive();
        step();
        chk("t1_latency_val",  bus.val_src,  1);
        chk("t1_latency_data", bus.data_src, 64'hA0);
        drain();
        exp_ids = '{2, 2, 2};
        cmp_ids("t1");
        if (got_data.size() >= 3) begin
            chk("t1_data0", got_data[0], 64'hA0);
            chk("t1_data1", got_data[1], 64'hB0);
            chk("t1_data2", got_data[2], 64'hC0);
        end
        cmp_no_bubble("t1", 3);

        // All four requesters valid: strict rotation from 0
        do_reset();
        start_capture();
        for (int r = 0; r < NR; r++) begin
            for (int b = 0; b < 6; b++) add(r, 64'h1000 + r * 16 + b, 1);
        end
        drive();
        drain();
        exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
        cmp_ids("t2");
        cmp_no_bubble("t2", 8);

        // Output stall holding beat D for five cycles
        clear();
        start_capture();
        bus.rdy_src = 1'b1;
        add(0, 64'hD0, 1);
        drive();
        step();
        chk("t3_load_data", bus.data_src, 64'hD0);
        bus.rdy_src = 1'b0;
        add(1, 64'hE0, 1);
        drive();
        for (int s = 0; s < 5; s++) begin
            step();
            chk("t3_hold_val",  bus.val_src,  1);
            chk("t3_hold_data", bus.data_src, 64'hD0);
            chk("t3_hold_id",   bus.id_src,   0);
            chk("t3_hold_rdy",  bus.rdy_snk,  0);
        end
        bus.rdy_src = 1'b1;
        step();
        chk("t3_next_data", bus.data_src, 64'hE0);
        chk("t3_next_id",   bus.id_src,   1);
        drain();

        // Requester 1 three-beat packet against 0 and 2
        do_reset();
        add(0, 64'h50, 1);
        drive();
        drain();
        clear();
        start_capture();
        add(1, 64'h11, 0); add(1, 64'h12, 0); add(1, 64'h13, 1);
        add(0, 64'h01, 1); add(0, 64'h02, 1);
        add(2, 64'h21, 1); add(2, 64'h22, 1);
        drive();
        drain();
`ifdef STREAM_ARB_PKT_LOCK_EN
        exp_ids = '{1, 1, 1, 2, 0, 2, 0};
`else
        exp_ids = '{1, 2, 0, 1, 2, 0, 1};
`endif
        cmp_ids("t4");

        // Reset in the middle of a four-beat packet from requester 3
        do_reset();
        add(3, 64'h31, 0); add(3, 64'h32, 0); add(3, 64'h33, 0); add(3, 64'h34, 1);
        drive();
        step();
        step();
        aresetn = 1'b0;
        #1;
        chk("t5_async_val",  bus.val_src,  0);
        chk("t5_async_id",   bus.id_src,   0);
        chk("t5_async_last", bus.last_src, 0);
        clear();
        drive();
        step();
        step();
        start_capture();
        add(0, 64'h61, 1); add(0, 64'h62, 1);
        add(1, 64'h71, 1); add(1, 64'h72, 1);
        add(3, 64'h3A, 1);
        aresetn = 1'b1;
        drive();
        drain();
        exp_ids = '{0, 1, 3, 0, 1};
        cmp_ids("t5");

        // Single-requester build mirrors its input one cycle later
        for (int k = 0; k < 10; k++) begin
            bus1.val_snk[0]  = ((k % 2) == 0);
            bus1.data_snk[0] = 64'h100 + k;
            bus1.last_snk[0] = ((k / 2) % 2) == 1;
            #1;
            chk("n1_rdy", bus1.rdy_snk, ((k % 2) == 0));
            step();
            chk("n1_val", bus1.val_src, ((k % 2) == 0));
            if ((k % 2) == 0) begin
                chk("n1_data", bus1.data_src, 64'h100 + k);
                chk("n1_last", bus1.last_src, ((k / 2) % 2) == 1);
            end
            chk("n1_id", bus1.id_src, 0);
        end
        bus1.val_snk = '0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
